fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Instruction-fetch stage and PC sequencer sitting directly upstream of the main decoder.
//  Holds the PC and fetches one word from instruction memory over a req/ack handshake.
//  Presents the word as instr (OP = instr[31:26], rt field = instr[20:16]) to the decoder.
//  Takes the decoder's Jump/Branch/Not/PCSrc1 plus ALU Zero to pick the next PC when the
//  datapath reports execution complete. Multi-cycle: one instruction in flight at a time.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded at reset
//  MAX_WAIT  15             max FETCH cycles without imem_ack before fetch_err (1..2^WAIT_W-1)
//  WAIT_W    4              width of wait counter
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request, high for whole FETCH state
//  imem_addr    out  32  byte address of fetch (= pc), stable while imem_req
//  imem_ack     in   1   imem_rdata valid this cycle; sampled only in FETCH
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  instruction register, to decoder / register file / extender
//  instr_valid  out  1   high in EXEC: instr is stable and being executed
//  pc           out  32  address of instr
//  pc_plus4     out  32  pc + 4 (jal link value, WriteBackSrc path)
//  exec_done    in   1   datapath finished current instr; control inputs valid this cycle
//  Jump         in   1   decoder: j/jal
//  Branch       in   1   decoder: conditional branch
//  Not          in   1   decoder: invert branch condition
//  PCSrc1       in   1   decoder: R-type (jr candidate)
//  Zero         in   1   ALU zero flag
//  rs_data      in   32  GPR[rs], jr target
//  retired      out  32  count of completed instructions
//  fetch_err    out  1   sticky error: fetch timeout or misaligned next PC
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, instr=0, retired=0, fetch_err=0,
//   wait_cnt=0; outputs imem_req=0, instr_valid=0. rst overrides everything, any state.
//  States (Moore outputs): IDLE, FETCH, EXEC, HALT.
//   IDLE : -> FETCH next cycle unconditionally.
//   FETCH: imem_req=1, imem_addr=pc. If imem_ack: instr<=imem_rdata, wait_cnt<=0, -> EXEC.
//          Else wait_cnt++; if wait_cnt==MAX_WAIT-1 on a non-ack cycle -> HALT, fetch_err<=1.
//          Ack arriving in the same cycle as the limit wins (fetch succeeds).
//   EXEC : instr_valid=1. Hold until exec_done. On exec_done: retired<=retired+1 (wraps mod 2^32);
//          if next_pc[1:0]!=0 -> HALT, fetch_err<=1, pc unchanged; else pc<=next_pc, -> FETCH.
//   HALT : imem_req=0, instr_valid=0; stays until rst.
//  Minimum latency: ack in first FETCH cycle -> instr_valid next cycle; 2 cycles/instr minimum.
//  imem_ack outside FETCH and exec_done outside EXEC are ignored.
//  Next-PC (combinational, evaluated on exec_done), priority high->low:
//   jr    : PCSrc1 & instr[5:0]==6'h08           -> rs_data
//   jump  : Jump                                  -> {pc_plus4[31:28], instr[25:0], 2'b00}
//   branch: Branch & (Zero ^ Not)                 -> pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
//   else                                          -> pc_plus4
//  All adds 32-bit, carry out discarded (wrap 32'hFFFF_FFFC+4 -> 0).
//  Reset mid-FETCH abandons request (imem_req low next cycle); pending ack ignored.
// TESTING
//  1 Reset, ack every first FETCH cycle: imem_addr 0x3000,0x3004,0x3008; instr_valid 1-of-2 cycles.
//  2 beq at 0x3000, imm=16'h0004, Zero=1,Not=0 -> next fetch 0x3014; Zero=0 -> 0x3004.
//  3 bne imm=16'hFFFF, Not=1, Zero=0 at pc 0x3008 -> next pc 0x3008; j instr[25:0]=26'h0000C03 -> 0x300C.
//  4 jr (PCSrc1=1, funct 0x08) rs_data=0x3100 -> 0x3100; rs_data=0x3102 -> HALT, fetch_err=1, retired+1.
//  5 Withhold ack 15 cycles -> fetch_err=1 in HALT; ack on 15th cycle instead -> normal EXEC.
//  6 Assert rst during FETCH wait and during EXEC -> IDLE, pc=0x3000, retired=0, fetch_err=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage and PC sequencer: fetches one word over req/ack,
// holds it for the decoder, and picks the next PC once the datapath retires it.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Not,
  input  logic        PCSrc1,
  input  logic        Zero,
  input  logic [31:0] rs_data,
  output logic [31:0] retired,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       retired_q, retired_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [31:0] pc_p4, br_off, next_pc;

  assign pc_p4  = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Highest priority first: jr, jump, taken branch, fall-through.
  always_comb begin
    next_pc = pc_p4;
    if (PCSrc1 && instr_q[5:0] == 6'h08)
      next_pc = rs_data;
    else if (Jump)
      next_pc = {pc_p4[31:28], instr_q[25:0], 2'b00};
    else if (Branch && (Zero ^ Not))
      next_pc = pc_p4 + br_off;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    err_d     = err_q;
    wait_d    = wait_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = EXEC;
        end else begin
          // ack on the limit cycle is handled above, so only a true miss times out
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LIM) begin
            state_d = HALT;
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        if (exec_done) begin
          retired_d = retired_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_p4;
  assign retired     = retired_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, branches, jumps, jr,
// fetch timeout, PC wrap and mid-flight reset.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done = 1'b0;
  logic        Jump = 1'b0, Branch = 1'b0, Not = 1'b0, PCSrc1 = 1'b0, Zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] retired;
  logic        fetch_err;

  int pass_cnt = 0;
  int total    = 0;

  localparam logic [31:0] I_BEQ = 32'h1022_0004;  // beq r1,r2,+4
  localparam logic [31:0] I_BNE = 32'h1422_FFFF;  // bne r1,r2,-1
  localparam logic [31:0] I_J   = 32'h0800_0C03;  // j 0x300C
  localparam logic [31:0] I_JR  = 32'h03E0_0008;  // jr r31

  fetch_pc_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .exec_done(exec_done), .Jump(Jump), .Branch(Branch), .Not(Not), .PCSrc1(PCSrc1),
    .Zero(Zero), .rs_data(rs_data), .retired(retired), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w; tick(); imem_ack = 1'b0;
  endtask

  task automatic exec(input logic j, b, n, p, z, input logic [31:0] rs);
    Jump = j; Branch = b; Not = n; PCSrc1 = p; Zero = z; rs_data = rs;
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    Jump = 0; Branch = 0; Not = 0; PCSrc1 = 0; Zero = 0; rs_data = '0;
  endtask

  task automatic test_reset();
    imem_ack = 1'b1; exec_done = 1'b1;
    do_reset();
    imem_ack = 1'b0; exec_done = 1'b0;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else pass_cnt++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else pass_cnt++;
    total++; if (pc !== 32'h3000) $display("FAIL reset_pc got %h exp 00003000", pc); else pass_cnt++;
    total++; if (instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr); else pass_cnt++;
    total++; if (retired !== 32'h0) $display("FAIL reset_retired got %0d exp 0", retired); else pass_cnt++;
    total++; if (fetch_err !== 1'b0) $display("FAIL reset_err got %b exp 0", fetch_err); else pass_cnt++;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL idle_to_fetch got %b exp 1", imem_req); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a;
    for (int i = 0; i < 3; i++) begin
      exp_a = 32'h3000 + 32'(4 * i);
      total++; if (imem_addr !== exp_a || imem_req !== 1'b1)
        $display("FAIL seq_addr%0d got %h/%b exp %h/1", i, imem_addr, imem_req, exp_a); else pass_cnt++;
      fetch(32'h0000_0000 + 32'(i));
      total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'(i))
        $display("FAIL seq_exec%0d got v=%b r=%b i=%h exp v=1 r=0 i=%h", i, instr_valid, imem_req, instr, 32'(i)); else pass_cnt++;
      exec(0, 0, 0, 0, 0, '0);
      total++; if (instr_valid !== 1'b0) $display("FAIL seq_valid_drop%0d got %b exp 0", i, instr_valid); else pass_cnt++;
    end
    total++; if (retired !== 32'd3) $display("FAIL seq_retired got %0d exp 3", retired); else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset(); tick(); fetch(I_BEQ);
    total++; if (pc_plus4 !== 32'h3004) $display("FAIL beq_pcp4 got %h exp 00003004", pc_plus4); else pass_cnt++;
    exec(0, 1, 0, 0, 1, '0);
    total++; if (imem_addr !== 32'h3014) $display("FAIL beq_taken got %h exp 00003014", imem_addr); else pass_cnt++;
    do_reset(); tick(); fetch(I_BEQ);
    exec(0, 1, 0, 0, 0, '0);
    total++; if (imem_addr !== 32'h3004) $display("FAIL beq_not_taken got %h exp 00003004", imem_addr); else pass_cnt++;
  endtask

  task automatic test_bne_jump();
    do_reset(); tick();
    fetch(0); exec(0, 0, 0, 0, 0, '0);
    fetch(0); exec(0, 0, 0, 0, 0, '0);
    total++; if (imem_addr !== 32'h3008) $display("FAIL bne_setup got %h exp 00003008", imem_addr); else pass_cnt++;
    fetch(I_BNE); exec(0, 1, 1, 0, 0, '0);
    total++; if (imem_addr !== 32'h3008) $display("FAIL bne_back got %h exp 00003008", imem_addr); else pass_cnt++;
    fetch(I_J); exec(1, 0, 0, 0, 0, '0);
    total++; if (imem_addr !== 32'h300C) $display("FAIL jump got %h exp 0000300c", imem_addr); else pass_cnt++;
    total++; if (retired !== 32'd4) $display("FAIL jump_retired got %0d exp 4", retired); else pass_cnt++;
  endtask

  task automatic test_jr();
    do_reset(); tick();
    fetch(I_JR); exec(0, 0, 0, 1, 0, 32'h3100);
    total++; if (imem_addr !== 32'h3100) $display("FAIL jr got %h exp 00003100", imem_addr); else pass_cnt++;
    fetch(I_JR); exec(0, 0, 0, 1, 0, 32'h3102);
    total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL jr_misalign got err=%b req=%b v=%b exp 1/0/0", fetch_err, imem_req, instr_valid); else pass_cnt++;
    total++; if (retired !== 32'd2 || pc !== 32'h3100)
      $display("FAIL jr_halt_state got ret=%0d pc=%h exp 2/00003100", retired, pc); else pass_cnt++;
    imem_ack = 1'b1; exec_done = 1'b1; tick(); tick(); imem_ack = 1'b0; exec_done = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || retired !== 32'd2)
      $display("FAIL halt_sticky got req=%b v=%b ret=%0d exp 0/0/2", imem_req, instr_valid, retired); else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset(); tick();
    for (int i = 0; i < 14; i++) tick();
    total++; if (imem_req !== 1'b1 || fetch_err !== 1'b0)
      $display("FAIL wait14 got req=%b err=%b exp 1/0", imem_req, fetch_err); else pass_cnt++;
    tick();
    total++; if (imem_req !== 1'b0 || fetch_err !== 1'b1)
      $display("FAIL timeout got req=%b err=%b exp 0/1", imem_req, fetch_err); else pass_cnt++;
    do_reset();
    total++; if (fetch_err !== 1'b0) $display("FAIL err_clear got %b exp 0", fetch_err); else pass_cnt++;
    tick();
    for (int i = 0; i < 14; i++) tick();
    fetch(32'hCAFE_0000);
    total++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0 || instr !== 32'hCAFE_0000)
      $display("FAIL ack_at_limit got v=%b err=%b i=%h exp 1/0/cafe0000", instr_valid, fetch_err, instr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset(); tick();
    fetch(I_JR); exec(1, 0, 0, 1, 0, 32'hFFFF_FFFC);
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL jr_priority got %h exp fffffffc", imem_addr); else pass_cnt++;
    fetch(0);
    total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pcp4 got %h exp 0", pc_plus4); else pass_cnt++;
    exec(0, 0, 0, 0, 0, '0);
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr got %h exp 0", imem_addr); else pass_cnt++;
    exec_done = 1'b1; PCSrc1 = 1'b1; rs_data = 32'h4000; tick();
    exec_done = 1'b0; PCSrc1 = 1'b0; rs_data = '0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || retired !== 32'd2)
      $display("FAIL done_in_fetch got req=%b a=%h ret=%0d exp 1/0/2", imem_req, imem_addr, retired); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset(); tick(); tick(); tick();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
    rst = 1'b0; imem_ack = 1'b0;
    total++; if (imem_req !== 1'b0 || pc !== 32'h3000 || instr !== 32'h0)
      $display("FAIL rst_fetch got req=%b pc=%h i=%h exp 0/00003000/0", imem_req, pc, instr); else pass_cnt++;
    tick();
    fetch(32'h1111_1111); exec(0, 0, 0, 0, 0, '0); fetch(32'h2222_2222);
    total++; if (instr_valid !== 1'b1 || pc !== 32'h3004 || retired !== 32'd1)
      $display("FAIL rst_exec_setup got v=%b pc=%h ret=%0d exp 1/00003004/1", instr_valid, pc, retired); else pass_cnt++;
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (instr_valid !== 1'b0 || pc !== 32'h3000 || retired !== 32'd0 || fetch_err !== 1'b0 || instr !== 32'h0)
      $display("FAIL rst_exec got v=%b pc=%h ret=%0d err=%b i=%h exp 0/00003000/0/0/0",
               instr_valid, pc, retired, fetch_err, instr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_bne_jump();
    test_jr();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
